// File: rtl/dual_port_blockram_pkg.sv
// rtl/dual_port_blockram_pkg.sv - shared constants and state encoding for dual_port_blockram
package dual_port_blockram_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;

  typedef enum logic {
    BLOCKRAM_STATE_INIT  = 1'b0,
    BLOCKRAM_STATE_READY = 1'b1
  } blockram_state_e;

endpackage

// File: rtl/dual_port_blockram_read_pipeline.sv
// rtl/dual_port_blockram_read_pipeline.sv - delay line for read data+valid; MSB of each stage is the valid bit
module dual_port_blockram_read_pipeline #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 65
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] stage_i,
  output logic [WIDTH-1:0] stage_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] src_d   [STAGES];

  always_comb begin
    src_d[0] = stage_i;
    for (int i = 1; i < STAGES; i++) begin
      src_d[i] = stage_q[i-1];
    end
  end

  // Data only advances alongside a valid bit so the last stage holds its value between reads.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i][WIDTH-1] <= src_d[i][WIDTH-1];
        if (src_d[i][WIDTH-1]) begin
          stage_q[i][WIDTH-2:0] <= src_d[i][WIDTH-2:0];
        end
      end
    end
  end

  assign stage_o = stage_q[STAGES-1];

endmodule

// File: rtl/dual_port_blockram.sv
// rtl/dual_port_blockram.sv - 1R1W block RAM with byte mask, write-first forwarding and self-initialisation
module dual_port_blockram
  import dual_port_blockram_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int READ_LATENCY              = 1,
  parameter logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
  input  logic                                 read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
  output logic                                 read_valid_out,
  output logic                                 init_done_out
);

  localparam int AW    = SET_PTR_WIDTH_IN_BITS;
  localparam int DW    = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int DEPTH = 1 << AW;
  // One bit per encodable address, set where the address maps onto a real entry.
  localparam logic [DEPTH-1:0] IN_RANGE_MAP = {DEPTH{1'b1}} >> (DEPTH - NUM_SET);
  localparam logic [AW-1:0]    LAST_IDX     = AW'(NUM_SET - 1);

  blockram_state_e state_q;
  logic [AW-1:0]   init_ptr_q;
  logic            init_done_q;

  logic [DW-1:0]   mem_q [NUM_SET];

  logic            ready;
  logic            wr_go;
  logic            rd_go;
  logic [DW-1:0]   rd_word_d;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic [DW:0]     pipe_out;

  assign ready = (state_q == BLOCKRAM_STATE_READY) && !reset_in;
  assign wr_go = ready && (|write_en_in) && IN_RANGE_MAP[write_set_addr_in];
  assign rd_go = ready && read_en_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= BLOCKRAM_STATE_INIT;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == BLOCKRAM_STATE_INIT) begin
      init_ptr_q <= init_ptr_q + 1'b1;
      if (init_ptr_q == LAST_IDX) begin
        state_q     <= BLOCKRAM_STATE_READY;
        init_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (state_q == BLOCKRAM_STATE_INIT && !reset_in) begin
      mem_q[init_ptr_q] <= INIT_VALUE;
    end else if (wr_go) begin
      for (int b = 0; b < WRITE_MASK_LEN; b++) begin
        if (write_en_in[b]) begin
          mem_q[write_set_addr_in][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
            write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
        end
      end
    end
  end

  // Write-first: a same-cycle write to the read address overrides the stored bytes it masks.
  always_comb begin
    rd_word_d = INIT_VALUE;
    if (IN_RANGE_MAP[read_set_addr_in]) begin
      rd_word_d = mem_q[read_set_addr_in];
      if (wr_go && (write_set_addr_in == read_set_addr_in)) begin
        for (int b = 0; b < WRITE_MASK_LEN; b++) begin
          if (write_en_in[b]) begin
            rd_word_d[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
              write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) begin
        rd_data_q <= rd_word_d;
      end
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    dual_port_blockram_read_pipeline #(
      .STAGES (READ_LATENCY - 1),
      .WIDTH  (DW + 1)
    ) u_read_pipeline (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .stage_i  ({rd_valid_q, rd_data_q}),
      .stage_o  (pipe_out)
    );
  end else begin : g_no_pipe
    assign pipe_out = {rd_valid_q, rd_data_q};
  end

  assign read_valid_out = pipe_out[DW];
  assign read_entry_out = pipe_out[DW-1:0];
  assign init_done_out  = init_done_q;

endmodule

// File: tb/tb_dual_port_blockram.sv
// tb/tb_dual_port_blockram.sv - random and directed checks of two RAM instances (latency 1 and 3) against a reference model
module tb_dual_port_blockram;

  localparam int NSET = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  we;
  logic [5:0]  waddr;
  logic [63:0] wdata;
  logic        re;
  logic [5:0]  raddr;

  logic [63:0] d1, d3;
  logic        v1, v3, done1, done3;

  always #5 clk = ~clk;

  dual_port_blockram #(.READ_LATENCY(1)) u_dut_l1 (
    .clk_in(clk), .reset_in(rst), .write_en_in(we), .write_set_addr_in(waddr),
    .write_entry_in(wdata), .read_en_in(re), .read_set_addr_in(raddr),
    .read_entry_out(d1), .read_valid_out(v1), .init_done_out(done1)
  );

  dual_port_blockram #(.READ_LATENCY(3)) u_dut_l3 (
    .clk_in(clk), .reset_in(rst), .write_en_in(we), .write_set_addr_in(waddr),
    .write_entry_in(wdata), .read_en_in(re), .read_set_addr_in(raddr),
    .read_entry_out(d3), .read_valid_out(v3), .init_done_out(done3)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_t;

  logic [63:0] ref_mem [NSET];
  rd_t         q1[$];
  rd_t         q3[$];
  int          init_cnt;
  int          edge_n;
  logic        exp_done, ev1, ev3;
  logic [63:0] ed1, ed3;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] cap1, cap3;
  int          pulses1, pulses3, vedge1, vedge3;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
  endtask

  // Expected outputs after each edge: memory as an array, reads as due-time queues per latency.
  task automatic model_edge();
    rd_t e;
    edge_n++;
    if (rst) begin
      init_cnt = 0;
      q1.delete();
      q3.delete();
      ev1 = 1'b0; ev3 = 1'b0;
      ed1 = '0;   ed3 = '0;
      exp_done = 1'b0;
      for (int i = 0; i < NSET; i++) ref_mem[i] = '0;
    end else begin
      if (init_cnt < NSET) begin
        init_cnt++;
        exp_done = (init_cnt == NSET);
      end else begin
        for (int b = 0; b < 8; b++)
          if (we[b]) ref_mem[waddr][b*8 +: 8] = wdata[b*8 +: 8];
        if (re) begin
          e.data = ref_mem[raddr];
          e.due  = edge_n;
          q1.push_back(e);
          e.due  = edge_n + 2;
          q3.push_back(e);
        end
      end
      ev1 = 1'b0;
      ev3 = 1'b0;
      if (q1.size() > 0 && q1[0].due == edge_n) begin e = q1.pop_front(); ed1 = e.data; ev1 = 1'b1; end
      if (q3.size() > 0 && q3[0].due == edge_n) begin e = q3.pop_front(); ed3 = e.data; ev3 = 1'b1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("done_l1", done1, exp_done);
    check_eq("done_l3", done3, exp_done);
    check_eq("valid_l1", v1, ev1);
    check_eq("valid_l3", v3, ev3);
    check_eq("data_l1", d1, ed1);
    check_eq("data_l3", d3, ed3);
    if (v1 === 1'b1) begin cap1 = d1; pulses1++; vedge1 = edge_n; end
    if (v3 === 1'b1) begin cap3 = d3; pulses3++; vedge3 = edge_n; end
  endtask

  task automatic drive(input logic [7:0] m, input int wa, input logic [63:0] wd, input logic r, input int ra);
    we = m; waddr = 6'(wa); wdata = wd; re = r; raddr = 6'(ra);
    cycle();
    we = '0; re = 1'b0;
  endtask

  task automatic flush();
    repeat (4) cycle();
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check_eq(tag, n, NSET);
  endtask

  initial begin
    int acc;
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
    edge_n = 0; init_cnt = 0; exp_done = 1'b0;
    ev1 = 1'b0; ev3 = 1'b0; ed1 = '0; ed3 = '0;
    cap1 = '1; cap3 = '1; pulses1 = 0; pulses3 = 0; vedge1 = 0; vedge3 = 0;

    cycle();
    cycle();
    rst = 1'b0;
    wait_init("init_latency");

    drive(8'h00, 0, 64'h0, 1'b1, 10);
    flush();
    check_eq("init_read_l1", cap1, 64'h0);
    check_eq("init_read_l3", cap3, 64'h0);

    drive(8'hFF, 63, 64'hFFFFFFFF00000000, 1'b0, 0);
    drive(8'h00, 0, 64'h0, 1'b1, 63);
    acc = edge_n;
    flush();
    check_eq("basic_l1", cap1, 64'hFFFFFFFF00000000);
    check_eq("basic_l3", cap3, 64'hFFFFFFFF00000000);
    check_eq("latency_l1", vedge1 - acc, 0);
    check_eq("latency_l3", vedge3 - acc, 2);

    drive(8'hFF, 62, 64'h0, 1'b0, 0);
    drive(8'b11001100, 62, '1, 1'b0, 0);
    drive(8'h00, 0, 64'h0, 1'b1, 62);
    flush();
    check_eq("mask_l1", cap1, 64'hFFFF0000FFFF0000);
    check_eq("mask_l3", cap3, 64'hFFFF0000FFFF0000);

    drive(8'hFF, 5, 64'h1111111111111111, 1'b0, 0);
    drive(8'h0F, 5, 64'hAAAAAAAAAAAAAAAA, 1'b1, 5);
    flush();
    check_eq("collision_l1", cap1, 64'h11111111AAAAAAAA);
    check_eq("collision_l3", cap3, 64'h11111111AAAAAAAA);

    for (int i = 0; i < 4; i++) drive(8'hFF, i, 64'hC0DE000000000000 + 64'(i), 1'b0, 0);
    pulses1 = 0; pulses3 = 0;
    for (int i = 0; i < 4; i++) drive(8'h00, 0, 64'h0, 1'b1, i);
    flush();
    check_eq("b2b_pulses_l1", pulses1, 4);
    check_eq("b2b_pulses_l3", pulses3, 4);
    check_eq("b2b_last_l3", cap3, 64'hC0DE000000000003);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            $urandom_range(0, 7), {$urandom, $urandom},
            1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end
    flush();

    drive(8'h00, 0, 64'h0, 1'b1, 63);
    pulses3 = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_init("reinit_latency");
    check_eq("midflight_drop_l3", pulses3, 0);
    cap1 = '1; cap3 = '1;
    drive(8'h00, 0, 64'h0, 1'b1, 63);
    flush();
    check_eq("post_reset_l1", cap1, 64'h0);
    check_eq("post_reset_l3", cap3, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_port_blockram.md
Name: dual_port_blockram

Overview:
Simple dual-port (1 read, 1 write) block RAM with per-byte write mask.
- Configurable read pipeline depth.
- Write-first forwarding when a read and a write hit the same address in the same cycle.
- Self-initialising: after reset it clears every entry to INIT_VALUE before accepting traffic.

Successor to the single-port storage primitive. Intended for cache tag/data arrays and queues that need a concurrent read and write each cycle.

Parameters:
SINGLE_ENTRY_SIZE_IN_BITS, 64, entry width; must be a multiple of `BYTE_LEN_IN_BITS
NUM_SET, 64, number of entries; need not be a power of two
SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width
WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS, byte-enable count
READ_LATENCY, 1, cycles from the read-accept edge to valid data; legal range 1..4
INIT_VALUE, 0, value written to every entry during initialisation

Ports:
clk_in  input  1  clock; all logic on the rising edge
reset_in  input  1  synchronous, active-high reset
write_en_in  input  WRITE_MASK_LEN  byte write enables; any bit set = write request
write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write address
write_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data
read_en_in  input  1  read request
read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read address
read_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  read data, registered
read_valid_out  output  1  one-cycle pulse marking read_entry_out valid
init_done_out  output  1  high when the RAM accepts traffic

Behaviour:
- Reset (sampled at an edge with reset_in=1):
  - state <= INIT; init_ptr <= 0.
  - read_entry_out <= 0; read_valid_out <= 0; init_done_out <= 0.
  - All read-pipeline valid bits cleared.
  - Memory contents are not guaranteed until INIT completes.
- State machine INIT:
  - Each cycle writes INIT_VALUE to mem[init_ptr], then init_ptr += 1.
  - The write of init_ptr == NUM_SET-1 moves the state to READY.
  - init_done_out is registered and rises on that same edge, so it is seen high exactly NUM_SET cycles after reset deasserts.
  - During INIT, write_en_in and read_en_in are ignored: no memory update, no read_valid_out.
- State machine READY:
  - Stays in READY until reset_in.
  - Reset mid-operation, including during INIT: pipeline is flushed, in-flight reads are dropped with no valid pulse, and INIT restarts from 0.
- Write (READY only):
  - At the edge, for each byte b with write_en_in[b]=1, mem[addr][b] <= write_entry_in[b]. Other bytes are unchanged.
  - Address >= NUM_SET: the write is dropped silently.
- Read (READY only):
  - Accepted at edge T when read_en_in=1.
  - Data appears on read_entry_out with read_valid_out=1 during the cycle following edge T+READ_LATENCY-1. READ_LATENCY=1 means registered data the cycle after the request.
  - Fully pipelined: one read per cycle, back-to-back, no bubbles.
  - Address >= NUM_SET returns INIT_VALUE, with valid still asserted.
- Collision (same address, read and write accepted in the same cycle):
  - Returns merged data: masked bytes come from write_entry_in, unmasked bytes from the old contents (write-first).
  - Reads issued after the write edge see the new data.
- Output hold: when read_valid_out=0, read_entry_out holds its last value.
- No back-pressure. The consumer must accept data on the valid cycle.

Decomposition:
- Shared package/header (parameters.h): `BYTE_LEN_IN_BITS (already present) and the state encoding constants BLOCKRAM_STATE_INIT and BLOCKRAM_STATE_READY.
- Sub-module blockram_read_pipeline:
  - Parameters: READ_LATENCY-1 stages; width SINGLE_ENTRY_SIZE_IN_BITS+1 (data + valid).
  - Synchronous clear on reset_in.
  - Instantiate it after the first-stage array read register.

Test Plan:
1. Init: pulse reset_in for 2 cycles, then release -> init_done_out=0 for 63 cycles and rises after 64. A read of addr 10 then returns 0 with read_valid_out=1.
2. Basic and latency check, for READ_LATENCY=1 and for 3: write 0xFFFFFFFF00000000 to addr 63, then read addr 63 -> read_entry_out=0xFFFFFFFF00000000. Valid pulses exactly READ_LATENCY cycles after the read-accept edge, and the data is never X.
3. Byte mask: write 0 to addr 62, then write all-ones with mask 8'b11001100 -> read returns 0xFFFF0000FFFF0000.
4. Collision: addr 5 holds 0x1111111111111111. Same cycle: write 0xAAAAAAAAAAAAAAAA with mask 8'h0F, and read addr 5 -> 0x11111111AAAAAAAA.
5. Back-to-back: write a different value to each of addrs 0..3. Issue 4 consecutive reads of addrs 0..3 -> 4 consecutive valid cycles with the matching data, in order.
6. Reset mid-flight: issue a read, then assert reset_in before the data returns -> no read_valid_out; init reruns; addr 63 reads 0 after init_done_out.
